// File: rtl/dram_block_master.sv
// dram_block_master: L2-side initiator for the subblock-streamed DRAM port.
// It accepts one whole-block read or write at a time. A write is sent as a
// gap-free burst of strobed subblocks. A read issues one en pulse and then
// reassembles the returned subblocks by strobe index.
// Optional feature macro: DRAM_BLOCK_MASTER_CHECK_EN. It enables the sticky
// proto_err flag and the RD_COLLECT timeout.
module dram_block_master #(
    parameter int ADDR_BITS   = 32,
    parameter int BLOCK_BITS  = 256,
    parameter int SUBBLOCKS   = 4,
    parameter int STROBE_BITS = 2
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic                              req_valid,
    input  logic                              req_we,
    input  logic [ADDR_BITS-1:0]              req_addr,
    input  logic [BLOCK_BITS-1:0]             req_wdata,
    output logic                              req_ready,
    output logic                              rsp_valid,
    output logic [BLOCK_BITS-1:0]             rsp_rdata,
    output logic [ADDR_BITS-1:0]              addr,
    output logic                              en,
    output logic                              we,
    output logic [STROBE_BITS-1:0]            dinDstrobe,
    output logic [BLOCK_BITS/SUBBLOCKS-1:0]   din,
    input  logic [STROBE_BITS-1:0]            doutDstrobe,
    input  logic [BLOCK_BITS/SUBBLOCKS-1:0]   dout,
    input  logic                              dready,
    input  logic                              accR,
    input  logic                              accW,
    output logic                              proto_err
);
    localparam int SB = BLOCK_BITS / SUBBLOCKS;
    localparam logic [ADDR_BITS-1:0]   OFF_MASK = ADDR_BITS'(BLOCK_BITS / 8 - 1);
    localparam logic [STROBE_BITS-1:0] LAST     = STROBE_BITS'(SUBBLOCKS - 1);
    localparam logic [STROBE_BITS-1:0] ONE      = STROBE_BITS'(1);

    // DONE holds the rsp_valid cycle outside IDLE, so a new request is taken one cycle later
    typedef enum logic [2:0] {IDLE, RD_WAIT_ACC, RD_COLLECT, WR_WAIT, WR_SEND, DONE} state_t;

    state_t                          state;
    logic [SUBBLOCKS-1:0][SB-1:0]    wbuf;
    logic [SUBBLOCKS-1:0][SB-1:0]    rbuf;
    logic [SUBBLOCKS-1:0][SB-1:0]    rbuf_next;
    logic [STROBE_BITS-1:0]          cnt;
    logic [STROBE_BITS-1:0]          cnt_inc;
    logic                            tmo;

    assign req_ready = (state == IDLE);
    assign cnt_inc   = cnt + ONE;

    // Read buffer including the subblock arriving this cycle (used to publish on the last beat)
    always_comb begin
        rbuf_next = rbuf;
        if (dready) rbuf_next[doutDstrobe] = dout;
    end

`ifdef DRAM_BLOCK_MASTER_CHECK_EN
    logic [6:0] tmr;
    assign tmo = (state == RD_COLLECT) && tmr[6];

    // Sticky protocol checker plus RD_COLLECT residency timer
    always_ff @(posedge clk) begin
        if (reset) begin
            proto_err <= 1'b0;
            tmr       <= '0;
        end else begin
            tmr <= (state == RD_COLLECT) ? tmr + 7'd1 : 7'd0;
            if (dready && ((state != RD_COLLECT) || (doutDstrobe != cnt))) proto_err <= 1'b1;
            if (tmo && !(dready && (cnt == LAST))) proto_err <= 1'b1;
        end
    end
`else
    assign tmo       = 1'b0;
    assign proto_err = 1'b0;
`endif

    // Transaction FSM; every DRAM-facing output is registered here
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            addr       <= '0;
            en         <= 1'b0;
            we         <= 1'b0;
            dinDstrobe <= '0;
            din        <= '0;
            rsp_valid  <= 1'b0;
            rsp_rdata  <= '0;
            wbuf       <= '0;
            rbuf       <= '0;
            cnt        <= '0;
        end else begin
            en        <= 1'b0;
            rsp_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        addr <= req_addr & ~OFF_MASK;
                        wbuf <= req_wdata;
                        cnt  <= '0;
                        if (req_we) begin
                            // accW already high: first subblock goes out next cycle
                            if (accW) begin
                                we         <= 1'b1;
                                dinDstrobe <= '0;
                                din        <= req_wdata[SB-1:0];
                                state      <= WR_SEND;
                            end else begin
                                state <= WR_WAIT;
                            end
                        end else begin
                            rbuf  <= '0;
                            state <= RD_WAIT_ACC;
                        end
                    end
                end
                RD_WAIT_ACC: begin
                    // Do not issue a read while a write may still be settling
                    if (accR && accW) begin
                        en    <= 1'b1;
                        state <= RD_COLLECT;
                    end
                end
                RD_COLLECT: begin
                    if (dready) begin
                        rbuf <= rbuf_next;
                        cnt  <= cnt_inc;
                        if (cnt == LAST) begin
                            rsp_rdata <= rbuf_next;
                            rsp_valid <= 1'b1;
                            state     <= DONE;
                        end
                    end else if (tmo) begin
                        rsp_valid <= 1'b1;
                        state     <= DONE;
                    end
                end
                WR_WAIT: begin
                    if (accW) begin
                        we         <= 1'b1;
                        dinDstrobe <= '0;
                        din        <= wbuf[0];
                        state      <= WR_SEND;
                    end
                end
                WR_SEND: begin
                    // Burst is not stalled by accW once started
                    if (cnt == LAST) begin
                        we         <= 1'b0;
                        dinDstrobe <= '0;
                        din        <= '0;
                        rsp_valid  <= 1'b1;
                        state      <= DONE;
                    end else begin
                        cnt        <= cnt_inc;
                        dinDstrobe <= cnt_inc;
                        din        <= wbuf[cnt_inc];
                    end
                end
                DONE: state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_dram_block_master.sv
// Directed self-checking bench for dram_block_master (default parameters).
module tb_dram_block_master;
    logic         clk = 1'b0;
    logic         reset;
    logic         req_valid, req_we;
    logic [31:0]  req_addr;
    logic [255:0] req_wdata;
    logic         req_ready, rsp_valid;
    logic [255:0] rsp_rdata;
    logic [31:0]  addr;
    logic         en, we;
    logic [1:0]   dinDstrobe;
    logic [63:0]  din;
    logic [1:0]   doutDstrobe;
    logic [63:0]  dout;
    logic         dready, accR, accW;
    logic         proto_err;

    int n_chk  = 0;
    int n_fail = 0;

    localparam logic [255:0] BLK1 = {64'h4444444444444444, 64'h3333333333333333,
                                     64'h2222222222222222, 64'h1111111111111111};
    localparam logic [255:0] BLK2 = {64'hDDDDDDDDDDDDDDDD, 64'hCCCCCCCCCCCCCCCC,
                                     64'hBBBBBBBBBBBBBBBB, 64'hAAAAAAAAAAAAAAAA};

    dram_block_master dut (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_ready(req_ready),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .addr(addr), .en(en), .we(we),
        .dinDstrobe(dinDstrobe), .din(din), .doutDstrobe(doutDstrobe), .dout(dout),
        .dready(dready), .accR(accR), .accW(accW), .proto_err(proto_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Called at a negedge showing the first write beat; ends at the negedge showing rsp_valid
    task automatic wr_beats(input string tag, input logic [255:0] blk, input logic [31:0] a);
        for (int k = 0; k < 4; k++) begin
            chk({tag, "_we"}, 256'(we), 256'(1));
            chk({tag, "_strobe"}, 256'(dinDstrobe), 256'(k));
            chk({tag, "_din"}, 256'(din), 256'(blk[64*k +: 64]));
            if (en || addr !== a || rsp_valid) chk({tag, "_en_addr_rsp"}, {en, addr, rsp_valid}, {1'b0, a, 1'b0});
            @(negedge clk);
        end
        chk({tag, "_rsp"}, 256'(rsp_valid), 256'(1));
        chk({tag, "_idle_bus"}, {we, dinDstrobe, din}, '0);
    endtask

    // Issues a read (caller is at a negedge) and acts as DRAM: beats start 5 cycles after en
    task automatic do_read(input logic [31:0] a, input logic [255:0] blk, input logic [7:0] ord,
                           output int n_en, output int n_rsp, output logic [255:0] rd,
                           output logic [31:0] a_seen, output int n_ovl);
        int ec;
        logic [1:0] s;
        ec = -1; n_en = 0; n_rsp = 0; n_ovl = 0; rd = '0; a_seen = '0;
        req_valid = 1'b1; req_we = 1'b0; req_addr = a; accR = 1'b1; accW = 1'b1;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            req_valid = 1'b0;
            if (en) begin
                n_en++;
                if (ec < 0) begin ec = i; a_seen = addr; end
            end
            if (en && we) n_ovl++;
            if (rsp_valid) begin n_rsp++; rd = rsp_rdata; end
            if (ec >= 0 && i >= ec + 5 && i < ec + 9) begin
                s = ord[2*(i-ec-5) +: 2];
                dready = 1'b1; doutDstrobe = s; dout = blk[64*s +: 64];
            end else begin
                dready = 1'b0; doutDstrobe = '0; dout = '0;
            end
        end
    endtask

    int n_en, n_rsp, n_ovl, cnt_we, cnt_rsp;
    logic [255:0] rd;
    logic [31:0]  a_seen;
    logic         got_en;

    initial begin
        reset = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0;
        doutDstrobe = '0; dout = '0; dready = 1'b0; accR = 1'b0; accW = 1'b0;

        // Reset state
        repeat (100) @(negedge clk);
        chk("rst_outs", {en, we, rsp_valid, addr, dinDstrobe, din}, '0);
        chk("rst_ready", 256'(req_ready), 256'(1));
        chk("rst_rdata", rsp_rdata, '0);
        chk("rst_err", 256'(proto_err), 256'(0));
        reset = 1'b0;
        @(negedge clk);

        // Single write at 0x1000 with accW high
        req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h1000; req_wdata = BLK1;
        accW = 1'b1; accR = 1'b1;
        @(negedge clk);
        req_valid = 1'b0; req_we = 1'b0;
        wr_beats("wr1", BLK1, 32'h1000);
        chk("wr1_busy", 256'(req_ready), 256'(0));
        @(negedge clk);
        chk("wr1_ready", {req_ready, rsp_valid}, 256'(2'b10));

        // Read back 0x1000
        do_read(32'h1000, BLK1, 8'b11_10_01_00, n_en, n_rsp, rd, a_seen, n_ovl);
        chk("rd1_en_pulses", 256'(n_en), 256'(1));
        chk("rd1_rsp_pulses", 256'(n_rsp), 256'(1));
        chk("rd1_rdata", rd, BLK1);
        chk("rd1_en_we_ovl", 256'(n_ovl), 256'(0));

        // Unaligned read address is block-aligned on the DRAM port
        do_read(32'h101C, BLK1, 8'b11_10_01_00, n_en, n_rsp, rd, a_seen, n_ovl);
        chk("rd2_addr", 256'(a_seen), 256'(32'h1000));
        chk("rd2_rdata", rd, BLK1);

        // Back-to-back writes; second one waits out a 10-cycle accW low
        req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h3004; req_wdata = BLK2;
        accW = 1'b1;
        @(negedge clk);
        req_valid = 1'b0;
        wr_beats("wr3", BLK2, 32'h3000);
        req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h2000; req_wdata = BLK1;
        accW = 1'b0;
        @(negedge clk);
        chk("b2b_ready_after_rsp", 256'(req_ready), 256'(1));
        @(negedge clk);
        req_valid = 1'b0; req_we = 1'b0;
        chk("b2b_accepted", 256'(req_ready), 256'(0));
        cnt_we = 0;
        for (int i = 0; i < 10; i++) begin
            if (we) cnt_we++;
            @(negedge clk);
        end
        chk("b2b_wait_no_we", 256'(cnt_we), 256'(0));
        accW = 1'b1;
        @(negedge clk);
        accW = 1'b0;
        wr_beats("wr4", BLK1, 32'h2000);
        chk("wr_keeps_rdata", rsp_rdata, BLK1);
        accW = 1'b1;
        @(negedge clk);

        // Reset in the middle of a read, after en and before any dready
        req_valid = 1'b1; req_we = 1'b0; req_addr = 32'h4000;
        got_en = 1'b0;
        for (int i = 0; i < 10 && !got_en; i++) begin
            @(negedge clk);
            req_valid = 1'b0;
            if (en) got_en = 1'b1;
        end
        chk("rstmid_en_seen", 256'(got_en), 256'(1));
        reset = 1'b1;
        @(negedge clk);
        chk("rstmid_outs", {en, we, rsp_valid, addr, dinDstrobe, din}, '0);
        chk("rstmid_ready", 256'(req_ready), 256'(1));
        chk("rstmid_rdata", rsp_rdata, '0);
        reset = 1'b0;
        cnt_rsp = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (rsp_valid) cnt_rsp++;
        end
        chk("rstmid_no_rsp", 256'(cnt_rsp), 256'(0));

        // Out-of-order strobes 0,2,1,3: assembled by strobe index
        do_read(32'h5000, BLK2, 8'b11_01_10_00, n_en, n_rsp, rd, a_seen, n_ovl);
        chk("ooo_rsp_pulses", 256'(n_rsp), 256'(1));
        chk("ooo_rdata", rd, BLK2);
`ifdef DRAM_BLOCK_MASTER_CHECK_EN
        chk("ooo_err_set", 256'(proto_err), 256'(1));
        repeat (5) @(negedge clk);
        chk("ooo_err_sticky", 256'(proto_err), 256'(1));
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("ooo_err_cleared", 256'(proto_err), 256'(0));
`else
        chk("ooo_err_zero", 256'(proto_err), 256'(0));
`endif

        $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
        $finish;
    end
endmodule

// File: doc/dram_block_master.md
Name: dram_block_master

Overview:
- Initiator end of the L2-to-DRAM subblock streaming interface; drives the memory-side port the DRAM model responds on.
- Accepts one whole-block read (line fill) or write (writeback) from the L2 controller.
- Writes: serializes the block into strobed subblocks.
- Reads: issues a single enable pulse and reassembles the returned strobed subblocks into a block.
- Sits between L2 cache miss/evict logic and the DRAM port.

Parameters:
- ADDR_BITS, 32, byte address width
- BLOCK_BITS, 256, L2 block width in bits
- SUBBLOCKS, 4, subblocks per block (power of 2, ≥2)
- STROBE_BITS, 2, log2(SUBBLOCKS)

Ports:
- clk  in  1  clock
- reset  in  1  synchronous active-high reset
- req_valid  in  1  L2 request present
- req_we  in  1  1=write block, 0=read block
- req_addr  in  ADDR_BITS  byte address of the request
- req_wdata  in  BLOCK_BITS  block to write; subblock k = bits [SB*(k+1)-1 : SB*k], where SB = BLOCK_BITS/SUBBLOCKS
- req_ready  out  1  high only in IDLE
- rsp_valid  out  1  one-cycle completion pulse
- rsp_rdata  out  BLOCK_BITS  assembled read block; valid with rsp_valid when the request was a read
- addr  out  ADDR_BITS  DRAM address, block-aligned
- en  out  1  DRAM read enable
- we  out  1  DRAM write enable
- dinDstrobe  out  STROBE_BITS  index of the subblock being written
- din  out  SB  write subblock
- doutDstrobe  in  STROBE_BITS  index of the returned subblock
- dout  in  SB  returned subblock
- dready  in  1  returned subblock valid
- accR  in  1  DRAM can accept a read
- accW  in  1  DRAM can accept a write
- proto_err  out  1  sticky protocol error (only meaningful under the optional feature)

Behaviour:
- Reset: all outputs 0 except req_ready=1; state IDLE; internal counters and buffers cleared.
- Reset mid-transaction: abandons the transaction immediately; no rsp_valid is produced for it.
- Clocking: all state updates on posedge clk.

IDLE:
- req_ready=1.
- On req_valid, latch the request:
  - addr <= req_addr with the low log2(BLOCK_BITS/8) bits zeroed;
  - req_wdata and req_we captured.
- Next state: WR_WAIT if req_we, else RD_WAIT_ACC.
- req_ready is 0 in every other state; only one transaction is in flight.

RD_WAIT_ACC:
- Holds until accR=1 AND accW=1, so a read is never issued while a write is settling.
- en=1 for exactly one cycle, then go to RD_COLLECT; en=0 thereafter.

RD_COLLECT:
- Each cycle dready=1: write dout into buffer slot doutDstrobe; increment the receive count.
- When the SUBBLOCKS-th subblock is captured: next cycle rsp_valid=1 with the complete rsp_rdata, then IDLE.
- rsp_rdata holds its value until the next read completes.
- dready in any state other than RD_COLLECT is ignored.

WR_WAIT:
- Holds until accW=1.

WR_SEND:
- SUBBLOCKS consecutive cycles with we=1; cycle k drives dinDstrobe=k and din=subblock k.
- Strobes run 0..SUBBLOCKS-1, gap-free, and are not stalled by accW once started.
- addr is held for the whole burst; en=0 throughout.
- Cycle after the last subblock: we=0, rsp_valid=1, then IDLE.
- rsp_rdata is unchanged by writes.

Timing and signal rules:
- Write latency: req accepted at cycle 0 with accW=1 → we asserted cycles 1..SUBBLOCKS → rsp_valid at cycle SUBBLOCKS+1.
- Back-to-back: req_valid may re-assert in the same cycle as rsp_valid. It is accepted one cycle later, once IDLE is entered.
- Mutual exclusion: en and we are never high in the same cycle.
- Idle outputs: din and dinDstrobe are 0 when we=0.

Optional Feature:
- Macro: DRAM_BLOCK_MASTER_CHECK_EN.
- Defined: proto_err is set and stays set until reset on any of:
  - doutDstrobe not equal to the expected sequential receive count in RD_COLLECT;
  - dready seen outside RD_COLLECT;
  - more than 64 cycles in RD_COLLECT without completing.
- Defined, timeout case: the block forces the transition to IDLE and emits rsp_valid with whatever rsp_rdata holds.
- Undefined: proto_err tied to 0; no checking and no timeout.

Test Plan:
- Reset: reset held 100 cycles → en=we=rsp_valid=0, addr=0, req_ready=1.
- Write: req_we=1, req_addr=0x1000, subblocks 0x1111..., 0x2222..., 0x3333..., 0x4444..., accW=1 → we high 4 cycles with dinDstrobe 0,1,2,3 carrying those words; rsp_valid one cycle after.
- Read back: read 0x1000 against a DRAM model with read latency 5 → exactly one en pulse; 4 dready beats; rsp_valid pulse with rsp_rdata equal to the written block.
- Unaligned / back-to-back: read req_addr=0x101C → addr=0x1000; a second write issued right after a write waits in WR_WAIT while accW=0 (10-cycle write latency) and starts the cycle after accW rises.
- Reset mid-read: assert reset after en, before dready → all outputs return to reset values next cycle; no rsp_valid ever emitted.
- Check feature (CHECK_EN): return strobes 0,2,1,3 → proto_err=1 and held until reset. Without the macro, same stimulus → block assembled by strobe index and proto_err=0.
